// File: rtl/sram_pkg.sv
// Shared definitions for the external SRAM bank pin interface (sram_ctrl / sram_resp).
package sram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sram_state_e;

  localparam logic        SRAM_ACT     = 1'b0;
  localparam int unsigned SRAM_BE_W    = 4;
  localparam int unsigned SRAM_DATA_W  = 32;
  localparam int unsigned SRAM_PADDR_W = 20;

endpackage

// File: rtl/sram_bank_mem.sv
// Word array with byte-masked synchronous write and a registered read port.
module sram_bank_mem
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [SRAM_BE_W-1:0]   be,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  output logic [SRAM_DATA_W-1:0] rdata
);

  logic [SRAM_DATA_W-1:0] mem [2**ADDR_W];

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < SRAM_BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_resp.sv
// Responder model of one 32-bit asynchronous SRAM bank driven by sram_ctrl pins.
// Optional SRAM_BUS_CHECK_EN enables the sticky ERR protocol checker.
module sram_resp
  import sram_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W  = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CE_N,
  input  logic                    OE_N,
  input  logic                    WE_N,
  input  logic [SRAM_BE_W-1:0]    BE_N,
  input  logic [SRAM_PADDR_W-1:0] PADDR,
  input  logic [SRAM_DATA_W-1:0]  WDATA,
  output logic [SRAM_DATA_W-1:0]  RDATA,
  output logic                    ACK,
  output logic                    ERR
);

  sram_state_e            state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0]  lat_addr;
  logic                   lat_we_n;
  logic [SRAM_BE_W-1:0]   lat_be_n;
  logic [SRAM_DATA_W-1:0] lat_wdata;
  logic                   latch, commit, ack_d;
  logic [SRAM_DATA_W-1:0] rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    commit  = 1'b0;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CE_N == SRAM_ACT) begin
          latch   = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (CE_N != SRAM_ACT) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ACK       <= 1'b0;
      lat_addr  <= '0;
      lat_we_n  <= 1'b1;
      lat_be_n  <= '1;
      lat_wdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ACK     <= ack_d;
      if (latch) begin
        lat_addr  <= PADDR[MEM_ADDR_W-1:0];
        lat_we_n  <= WE_N;
        lat_be_n  <= BE_N;
        lat_wdata <= WDATA;
      end
    end
  end

  // Upper PADDR bits are dropped on purpose so the bank aliases.
  if (MEM_ADDR_W < SRAM_PADDR_W) begin : g_alias
    logic unused_paddr_hi;
    assign unused_paddr_hi = ^PADDR[SRAM_PADDR_W-1:MEM_ADDR_W];
  end

  sram_bank_mem #(
    .ADDR_W(MEM_ADDR_W)
  ) u_mem (
    .clk  (CLK),
    .rst_n(RST),
    .we   (commit && (lat_we_n == SRAM_ACT)),
    .be   (~lat_be_n),
    .re   (commit && (lat_we_n != SRAM_ACT)),
    .addr (lat_addr),
    .wdata(lat_wdata),
    .rdata(rdata_q)
  );

  assign RDATA = (OE_N == SRAM_ACT) ? rdata_q : '0;

`ifdef SRAM_BUS_CHECK_EN
  logic bus_bad;

  always_comb begin
    bus_bad = (CE_N == SRAM_ACT) && (OE_N == SRAM_ACT) && (WE_N == SRAM_ACT);
`ifndef SYNTHESIS
    if ($isunknown({CE_N, WE_N, OE_N, PADDR})) bus_bad = 1'b1;
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        ERR <= 1'b0;
    else if (bus_bad) ERR <= 1'b1;
  end
`else
  assign ERR = 1'b0;
`endif

endmodule
